// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and default geometry for the imem loader.
package imem_loader_pkg;
    localparam int ADDR_W_DEF = 8;
    localparam int CNT_W_DEF = 16;
    localparam int BYTES_PER_WORD = 4;
    localparam int IDX_W = $clog2(BYTES_PER_WORD);
    typedef enum logic [2:0] {LEN0, LEN1, LOAD, CSUM, DONE, ERR} state_t;
endpackage

// File: rtl/byte_packer.sv
// byte_packer: assembles little-endian bytes into a 32-bit word, pulsing word_valid after the last byte.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic [7:0]       din,
    output logic [31:0]      word,
    output logic             word_valid,
    output logic [IDX_W-1:0] idx
);
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            word <= '0;
            word_valid <= 1'b0;
            idx <= '0;
        end else begin
            word_valid <= en && idx == IDX_W'(BYTES_PER_WORD - 1);
            if (en) begin
                word[{idx, 3'b000} +: 8] <= din;
                idx <= idx + 1'b1;
            end
        end
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams a length-prefixed little-endian program into imem, holding the CPU in reset until done.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte over the payload.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              start,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              load_err
);
    localparam logic [CNT_W:0] DEPTH = (CNT_W + 1)'(1 << ADDR_W);
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t FIN = CSUM;
`else
    localparam state_t FIN = DONE;
`endif
    state_t state, nxt;
    logic [CNT_W-1:0] cnt, len;
    logic [ADDR_W:0] wcnt;
    logic [IDX_W-1:0] idx;
    logic accept, restart, last, pk_en;
    assign accept = rx_valid && rx_ready;
    assign restart = start && (state == DONE || state == ERR);
    assign pk_en = accept && state == LOAD;
    assign len = CNT_W'({rx_data, cnt[7:0]});
    assign last = (CNT_W'(wcnt) + CNT_W'(1)) == cnt;
    // the counter reaches DEPTH after the final write; hold the address at the top word
    assign imem_addr = wcnt[ADDR_W] ? '1 : wcnt[ADDR_W-1:0];
    assign cpu_reset = state != DONE;
    assign load_done = state == DONE;
    assign load_err = state == ERR;
    byte_packer u_packer (
        .clk(clk),
        .reset(reset),
        .clear(restart),
        .en(pk_en),
        .din(rx_data),
        .word(imem_wdata),
        .word_valid(imem_we),
        .idx(idx)
    );
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum;
    always_ff @(posedge clk) begin
        if (reset || restart) csum <= '0;
        else if (pk_en) csum <= csum ^ rx_data;
    end
`endif
    always_ff @(posedge clk) begin
        if (reset) state <= LEN0;
        else state <= nxt;
    end
    always_comb begin
        nxt = state;
        case (state)
            LEN0: nxt = accept ? LEN1 : LEN0;
            LEN1: nxt = !accept ? LEN1 : len == '0 ? FIN : {1'b0, len} > DEPTH ? ERR : LOAD;
            LOAD: nxt = imem_we && last ? FIN : LOAD;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: nxt = !accept ? CSUM : rx_data == csum ? DONE : ERR;
`endif
            DONE, ERR: nxt = start ? LEN0 : state;
            default: nxt = LEN0;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            cnt <= '0;
            wcnt <= '0;
        end else begin
            if (accept && state == LEN0) cnt[7:0] <= rx_data;
            if (accept && state == LEN1) cnt <= len;
            if (imem_we) wcnt <= wcnt + 1'b1;
        end
        // the write cycle after each completed word never accepts a byte
        rx_ready <= !reset && (nxt inside {LEN0, LEN1, LOAD, CSUM})
                    && !(pk_en && idx == IDX_W'(BYTES_PER_WORD - 1));
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader; expected writes queued at stimulus, popped on imem_we.
module tb_imem_loader;
    logic clk = 0, reset = 1, rx_valid = 0, start = 0;
    logic [7:0] rx_data = 0;
    logic rx_ready, imem_we, cpu_reset, load_done, load_err;
    logic [7:0] imem_addr;
    logic [31:0] imem_wdata;
    int vectors = 0, errors = 0, we_cnt = 0;
    logic [39:0] exp_q[$];
    logic [31:0] mem[0:255];
    logic [31:0] img[0:255];
    logic [7:0] last_addr;
    logic acc_q = 0;

    imem_loader dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .start(start), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_reset(cpu_reset), .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) acc_q <= rx_valid && rx_ready && !reset;

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            logic [39:0] e;
            we_cnt++;
            mem[imem_addr] = imem_wdata;
            last_addr = imem_addr;
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%h data=%h", imem_addr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({imem_addr, imem_wdata} !== e) begin
                    errors++;
                    $display("FAIL write got=%h/%h want=%h/%h", imem_addr, imem_wdata, e[39:32], e[31:0]);
                end
            end
            vectors++;
            if (acc_q !== 1'b1 || rx_ready !== 1'b0) begin
                errors++;
                $display("FAIL we_timing prev_accept=%b rx_ready=%b want 1/0", acc_q, rx_ready);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        rx_data = b;
        rx_valid = 1;
        while (rx_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_timeout byte=%h rx_ready=%b want 1", b, rx_ready);
        end
        @(negedge clk);
        rx_valid = 0;
    endtask

    task automatic send_word(input int a, input logic [31:0] w);
        exp_q.push_back({8'(a), w});
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
    endtask

    task automatic send_csum(input int n);
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0] x = 0;
        for (int i = 0; i < n; i++) x = x ^ img[i][7:0] ^ img[i][15:8] ^ img[i][23:16] ^ img[i][31:24];
        send_byte(x);
`else
        if (n < 0) $display("negative count %0d", n);
`endif
    endtask

    task automatic load(input int n);
        send_byte(8'(n));
        send_byte(8'(n >> 8));
        for (int i = 0; i < n; i++) send_word(i, img[i]);
        send_csum(n);
        @(negedge clk);
    endtask

    task automatic rearm();
        start = 1;
        @(negedge clk);
        start = 0;
        vectors++;
        if (load_done !== 0 || load_err !== 0 || cpu_reset !== 1 || rx_ready !== 1) begin
            errors++;
            $display("FAIL rearm done=%b err=%b cpu_reset=%b rdy=%b want 0/0/1/1", load_done, load_err, cpu_reset, rx_ready);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if ({rx_ready, imem_we, imem_addr, imem_wdata, cpu_reset, load_done, load_err} !== {2'b00, 8'h00, 32'h0, 3'b100}) begin
            errors++;
            $display("FAIL reset_outputs rdy=%b we=%b a=%h d=%h cr=%b dn=%b er=%b", rx_ready, imem_we, imem_addr, imem_wdata, cpu_reset, load_done, load_err);
        end
        reset = 0;
        @(negedge clk);
        vectors++;
        if (rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release rx_ready=%b want 1", rx_ready);
        end
    endtask

    task automatic test_basic();
        int w0 = we_cnt;
        img[0] = 32'h00500013;
        img[1] = 32'h00A00093;
        load(2);
        vectors++;
        if (we_cnt - w0 !== 2) begin errors++; $display("FAIL basic_we_count got=%0d want=2", we_cnt - w0); end
        vectors++;
        if (load_done !== 1 || cpu_reset !== 0 || load_err !== 0) begin
            errors++;
            $display("FAIL basic_done done=%b cpu_reset=%b err=%b want 1/0/0", load_done, cpu_reset, load_err);
        end
        vectors++;
        if (mem[0] !== 32'h00500013 || mem[1] !== 32'h00A00093) begin
            errors++;
            $display("FAIL basic_mem m0=%h m1=%h want 00500013/00a00093", mem[0], mem[1]);
        end
        vectors++;
        if (exp_q.size() !== 0) begin errors++; $display("FAIL basic_pending got=%0d want=0", exp_q.size()); end
        rearm();
    endtask

    task automatic test_zero();
        int w0 = we_cnt;
        load(0);
        vectors++;
        if (load_done !== 1 || cpu_reset !== 0 || we_cnt !== w0) begin
            errors++;
            $display("FAIL zero_done done=%b cpu_reset=%b writes=%0d want 1/0/0", load_done, cpu_reset, we_cnt - w0);
        end
        rearm();
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h01);
        @(negedge clk);
        vectors++;
        if (load_err !== 1 || cpu_reset !== 1 || load_done !== 0) begin
            errors++;
            $display("FAIL zero_badsum err=%b cpu_reset=%b done=%b want 1/1/0", load_err, cpu_reset, load_done);
        end
        rearm();
`endif
    endtask

    task automatic test_oversize();
        int w0 = we_cnt;
        send_byte(8'h01);
        send_byte(8'h01);
        repeat (4) @(negedge clk);
        vectors++;
        if (load_err !== 1 || cpu_reset !== 1 || load_done !== 0 || rx_ready !== 0 || we_cnt !== w0) begin
            errors++;
            $display("FAIL oversize err=%b cpu_reset=%b done=%b rdy=%b writes=%0d want 1/1/0/0/0", load_err, cpu_reset, load_done, rx_ready, we_cnt - w0);
        end
        start = 0;
        rearm();
        img[0] = 32'hDEADBEEF;
        load(1);
        vectors++;
        if (load_done !== 1 || load_err !== 0 || mem[0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL oversize_recover done=%b err=%b m0=%h want 1/0/deadbeef", load_done, load_err, mem[0]);
        end
        rearm();
    endtask

    task automatic test_full();
        for (int i = 0; i < 256; i++) img[i] = 32'hA5000000 | (i * 32'h00010203);
        load(256);
        vectors++;
        if (last_addr !== 8'hFF || load_done !== 1) begin
            errors++;
            $display("FAIL full_last addr=%h done=%b want ff/1", last_addr, load_done);
        end
        for (int i = 0; i < 256; i++) begin
            vectors++;
            if (mem[i] !== img[i]) begin
                errors++;
                $display("FAIL full_readback[%0d] got=%h want=%h", i, mem[i], img[i]);
            end
        end
        rearm();
    endtask

    task automatic test_stall();
        img[0] = 32'h11223344;
        img[1] = 32'h55667788;
        send_byte(8'h02);
        send_byte(8'h00);
        exp_q.push_back({8'h00, img[0]});
        send_byte(8'h44);
        send_byte(8'h33);
        repeat (10) @(negedge clk);
        vectors++;
        if (rx_ready !== 1 || imem_we !== 0) begin
            errors++;
            $display("FAIL stall_idle rdy=%b we=%b want 1/0", rx_ready, imem_we);
        end
        send_byte(8'h22);
        send_byte(8'h11);
        vectors++;
        if (imem_we !== 1 || rx_ready !== 0) begin
            errors++;
            $display("FAIL stall_write we=%b rdy=%b want 1/0", imem_we, rx_ready);
        end
        @(negedge clk);
        vectors++;
        if (imem_we !== 0 || rx_ready !== 1) begin
            errors++;
            $display("FAIL stall_resume we=%b rdy=%b want 0/1", imem_we, rx_ready);
        end
        send_word(1, img[1]);
        send_csum(2);
        @(negedge clk);
        vectors++;
        if (load_done !== 1 || mem[0] !== 32'h11223344 || mem[1] !== 32'h55667788) begin
            errors++;
            $display("FAIL stall_result done=%b m0=%h m1=%h want 1/11223344/55667788", load_done, mem[0], mem[1]);
        end
        rearm();
    endtask

    task automatic test_reset_mid();
        img[0] = 32'hCAFEF00D;
        send_byte(8'h02);
        send_byte(8'h00);
        send_word(0, img[0]);
        send_byte(8'h99);
        reset = 1;
        @(negedge clk);
        vectors++;
        if ({rx_ready, imem_we, imem_addr, imem_wdata, cpu_reset, load_done, load_err} !== {2'b00, 8'h00, 32'h0, 3'b100}) begin
            errors++;
            $display("FAIL reset_mid rdy=%b we=%b a=%h d=%h cr=%b dn=%b er=%b", rx_ready, imem_we, imem_addr, imem_wdata, cpu_reset, load_done, load_err);
        end
        reset = 0;
        @(negedge clk);
        img[0] = 32'h0BADC0DE;
        load(1);
        vectors++;
        if (load_done !== 1 || mem[0] !== 32'h0BADC0DE || exp_q.size() !== 0) begin
            errors++;
            $display("FAIL reset_mid_reload done=%b m0=%h pending=%0d want 1/0badc0de/0", load_done, mem[0], exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_oversize();
        test_full();
        test_stall();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
